video_cfg_scheduler: RTL
========================

# video_cfg_scheduler

Frame-synchronous configuration scheduler that sits between the host Avalon-MM master and the per-core control ports of the video pipeline cores (rgb2gray, and other pixel cores sharing the 32-bit `avs_*` register style). Host writes are queued in a FIFO and replayed to the addressed core only at the start of vertical blanking, so that bypass and mode changes never take effect mid-frame. A single shared address/data bus feeds all cores, with one write strobe per core.

## Interface
Parameters:
- `NUM_CORE`, 4: number of downstream cores.
- `CORE_AW`, 2: register address bits per core.
- `DEPTH`, 8: queue entries; must be a power of two and ≥ 2.
- `CSEL_W`, `max(1,$clog2(NUM_CORE))`: core-select bits (derived).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `avs_write` in 1: host write strobe.
- `avs_address` in `CSEL_W+CORE_AW`: `{core_sel, reg_addr}`.
- `avs_writedata` in 32: host write data.
- `avs_waitrequest` out 1: queue full; a host write is not accepted while this is high.
- `vblank` in 1: vertical blanking level from the VGA timing generator, synchronous to `clk`.
- `core_write` out `NUM_CORE`: one-hot write strobe, one bit per core.
- `core_address` out `CORE_AW`: shared register address.
- `core_writedata` out 32: shared write data.
- `pending` out `$clog2(DEPTH)+1`: current queue occupancy.
- `overrun` out 1: sticky flag; the drain was still running when `vblank` fell.

## Operation
- **Enqueue.** A write is accepted when `avs_write & ~avs_waitrequest`.
  - If `core_sel < NUM_CORE`, the entry `{core_sel, reg_addr, data}` is pushed.
  - If `core_sel >= NUM_CORE`, the write is accepted and silently dropped; nothing is pushed.
- **Full.** `avs_waitrequest = (count == DEPTH)`. It is decoded from the registered count only; a pop in the same cycle does not lower it.
- **Edge detect.** `vblank_q` is `vblank` registered. `blank_rise = vblank & ~vblank_q`.
- **State machine.**
  - **IDLE:**
    - On `blank_rise` with `count != 0`: load `drain_cnt <= count` and go to DRAIN.
    - On `blank_rise` with `count == 0`: stay in IDLE.
  - **DRAIN:**
    - Each cycle, pop the head entry.
    - Drive `core_write[sel] = 1`, plus `core_address` and `core_writedata`, all registered.
    - Decrement `drain_cnt`; when it reaches 1, return to IDLE after this pop.
- **Commit boundary.** Entries enqueued after the snapshot cycle are not drained in the current blank; they wait for the next `blank_rise`.
- **Simultaneous push and pop.** Both are allowed in the same cycle. `count` is unchanged and FIFO order is preserved.
- **Pointer wrap.** Pointers wrap modulo `DEPTH`.
- **Blank too short.** If `vblank` falls while in DRAIN:
  - `overrun` is set.
  - The drain still completes the snapshotted entries.
- **Repeat blank edge.** A `blank_rise` arriving while in DRAIN is ignored.
- **Reset.** `rst` in any state, including mid-drain:
  - Returns to IDLE and empties the queue.
  - Clears `vblank_q`, `overrun` and `drain_cnt`.
  - Forces all outputs to 0.
  - Entries still queued at that point are discarded.

## Timing
- **Reset values:** `core_write=0`, `core_address=0`, `core_writedata=0`, `pending=0`, `overrun=0`, `avs_waitrequest=0`.
- **Enqueue latency:** an accepted write at edge t makes `pending` increment after edge t.
- **Drain latency:**
  - `vblank` first sampled high at edge t (so `blank_rise` was true in the cycle before t) → DRAIN entered at t.
  - First `core_write` pulse is visible after edge t+1.
  - N entries produce N consecutive one-cycle strobes, ending after edge t+N.
- **Strobe properties:** `core_write` is high for exactly one cycle per entry and is never multi-hot.
- **Address/data validity:** `core_address` and `core_writedata` are valid only while a strobe is high; they hold their last value otherwise.
- **Throughput:**
  - Host side: 1 write per cycle while not full.
  - Drain side: 1 entry per cycle.

## Test plan
- **Basic deferral.**
  - Stimulus: with `vblank=0`, write `0x1` to core 0 at reg 0.
  - Required: `pending=1` and no `core_write` for 100 cycles.
  - Stimulus: raise `vblank`.
  - Required: `core_write=4'b0001`, `core_address=0`, `core_writedata=0x1` for one cycle, 2 cycles after the rise; then `pending=0`.
- **Full queue.**
  - Stimulus: 9 back-to-back writes to cores 0..3.
  - Required: `avs_waitrequest=1` after the 8th write is accepted and the 9th stalls.
  - Stimulus: blank rise.
  - Required: 8 consecutive strobes in FIFO order; `avs_waitrequest` drops after the first pop; the 9th write is then accepted and deferred to the next blank.
- **Commit boundary.**
  - Stimulus: 3 entries queued; blank rises; 1 more write arrives on the 2nd drain cycle.
  - Required: exactly 3 strobes; the 4th entry is applied at the next blank; `pending` stays 1 in between.
- **Overrun.**
  - Stimulus: 8 entries queued; `vblank` high for only 4 cycles.
  - Required: all 8 strobes still emitted and `overrun=1` until `rst`.
- **Invalid core.**
  - Stimulus: with `NUM_CORE=3`, write with `core_sel=3`.
  - Required: accepted, `pending` stays 0, no strobe at blank.
- **Reset mid-drain.**
  - Stimulus: assert `rst` during the 3rd of 6 strobes.
  - Required: next cycle `core_write=0`, `pending=0`, `overrun=0`; nothing emitted at the following blank.

Source files
------------

// File: rtl/video_cfg_scheduler.sv
// video_cfg_scheduler: queues host register writes and replays them to the addressed core at the start of vblank
module video_cfg_scheduler #(
   parameter int NUM_CORE = 4,
   parameter int CORE_AW = 2,
   parameter int DEPTH = 8,
   parameter int CSEL_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      avs_write,
   input  logic [CSEL_W+CORE_AW-1:0] avs_address,
   input  logic [31:0]               avs_writedata,
   output logic                      avs_waitrequest,
   input  logic                      vblank,
   output logic [NUM_CORE-1:0]       core_write,
   output logic [CORE_AW-1:0]        core_address,
   output logic [31:0]               core_writedata,
   output logic [$clog2(DEPTH):0]    pending,
   output logic                      overrun
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CSEL_W:0] NC = (CSEL_W+1)'(NUM_CORE);
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state, state_next;
   logic [CSEL_W-1:0] sel_mem [DEPTH];
   logic [CORE_AW-1:0] addr_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count, drain_cnt;
   logic vblank_q, blank_rise, push, pop;
   logic [NUM_CORE-1:0] head_hot;
   logic [CSEL_W-1:0] in_sel;
   assign in_sel = avs_address[CSEL_W+CORE_AW-1:CORE_AW];
   assign avs_waitrequest = (count == (PW+1)'(DEPTH));
   assign push = avs_write & ~avs_waitrequest & ({1'b0, in_sel} < NC);
   assign pop = (state == DRAIN);
   assign blank_rise = vblank & ~vblank_q;
   assign pending = count;
   always_comb begin
      state_next = (state == IDLE) ? ((blank_rise && count != '0) ? DRAIN : IDLE)
                                   : ((drain_cnt == (PW+1)'(1)) ? IDLE : DRAIN);
      head_hot = '0;
      for (int i = 0; i < NUM_CORE; i++) head_hot[i] = (sel_mem[rd_ptr] == CSEL_W'(i));
   end
   // drain_cnt snapshots the occupancy at blank start so later writes wait for the next blank
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         drain_cnt <= '0;
         vblank_q <= 1'b0;
         overrun <= 1'b0;
         core_write <= '0;
         core_address <= '0;
         core_writedata <= '0;
      end else begin
         state <= state_next;
         vblank_q <= vblank;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         drain_cnt <= (state == IDLE) ? ((state_next == DRAIN) ? count : drain_cnt) : drain_cnt - (PW+1)'(1);
         if (state == DRAIN && vblank_q && !vblank) overrun <= 1'b1;
         core_write <= pop ? head_hot : '0;
         if (pop) begin
            core_address <= addr_mem[rd_ptr];
            core_writedata <= data_mem[rd_ptr];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         sel_mem[wr_ptr] <= in_sel;
         addr_mem[wr_ptr] <= avs_address[CORE_AW-1:0];
         data_mem[wr_ptr] <= avs_writedata;
      end
   end
endmodule
